bitblade_acc: RTL and testbench
===============================

BITBLADE_ACC -- requirements
Module: bitblade_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 32: accumulator and result width in bits (ACC_W >= 18).
REQ-002 SHALL have parameter LEN_W, default 8: width of the beat-count field.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  number of partial-sum beats in the job; sampled with start.
REQ-007 SHALL have port in_valid  input  1  upstream partial sum is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port in_c  input  18  unsigned Bitblade partial sum (out_c of the upstream MAC).
REQ-010 SHALL have port out_valid  output  1  result is valid.
REQ-011 SHALL have port out_ready  input  1  downstream takes the result.
REQ-012 SHALL have port out_sum  output  ACC_W  accumulated result.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag for the current result.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ACC -> DONE -> IDLE.
REQ-016 In IDLE with start=1 and len!=0, the next state SHALL be ACC; acc, ovf and the beat counter clear; cnt loads len.
REQ-017 In IDLE with start=1 and len=0, the next state SHALL be DONE with out_sum=0 and ovf=0.
REQ-018 in_ready SHALL be 1 only in ACC (Moore output, no combinational path from in_valid).
REQ-019 A beat is accepted when in_valid && in_ready: acc <= acc + zero-extended in_c, and cnt decrements by 1.
REQ-020 Acceptance of the beat that takes cnt from 1 to 0 SHALL move the FSM to DONE.
REQ-021 out_valid SHALL rise on the cycle after the final beat is accepted (latency 1), with out_sum equal to the full sum.
REQ-022 In DONE, out_valid=1 and out_sum/ovf SHALL hold stable until out_ready=1; then the next state is IDLE.
REQ-023 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside ACC.
REQ-024 in_valid gaps in ACC SHALL stall the job without any change to acc or cnt.
REQ-025 Back-to-back jobs: start may be asserted the cycle the FSM returns to IDLE, giving a minimum of 1 idle cycle between results.

Reset
REQ-026 Asserting reset at any time, including mid-job, SHALL immediately force: state IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, out_sum=0, ovf=0, busy=0.
REQ-027 Any partial job interrupted by reset SHALL be discarded; no result is produced for it.

Configuration
REQ-028 Macro BITBLADE_ACC_SAT_EN defined: an addition whose true sum exceeds 2^ACC_W-1 SHALL clamp acc to 2^ACC_W-1 and set ovf; acc stays clamped for the rest of the job.
REQ-029 Macro BITBLADE_ACC_SAT_EN undefined: addition SHALL wrap modulo 2^ACC_W, and ovf SHALL be tied to 0.

Structure
REQ-030 The FSM state enum (IDLE/ACC/DONE), the default ACC_W/LEN_W and the constant PSUM_W=18 SHALL live in the shared package bitblade_pkg.
REQ-031 A single sub-module bitblade_sat_add (ACC_W + 18 -> ACC_W adder with saturate/carry-out) is natural; everything else stays flat.

Verification
REQ-032 Reset, then start with len=4, in_c=1,2,3,4 on consecutive cycles -> out_valid on the cycle after beat 4, out_sum=10, ovf=0.
REQ-033 Start with len=0 -> out_valid the next cycle, out_sum=0, no beat accepted (in_ready stays 0).
REQ-034 len=3 with in_valid toggling 1,0,1,0,1 and out_ready held 0 for 5 cycles -> out_sum=sum of the 3 beats, held stable, returns to IDLE the cycle after out_ready=1.
REQ-035 ACC_W=18, len=2, in_c=0x3FFFF twice -> with the macro: out_sum=0x3FFFF, ovf=1; without it: out_sum=0x3FFFE, ovf=0.
REQ-036 Reset asserted after 2 of 5 beats -> all outputs 0 asynchronously; a subsequent job with len=1, in_c=7 yields out_sum=7.

Source files
------------

// File: rtl/bitblade_pkg.sv
// Shared types and constants for the Bitblade partial-sum accumulator.
package bitblade_pkg;

  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned PSUM_W    = 18;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/bitblade_sat_add.sv
// Adds an 18-bit unsigned partial sum to an ACC_W-bit accumulator.
// SAT selects clamp-to-max on overflow; otherwise the sum wraps.
module bitblade_sat_add
  import bitblade_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter bit          SAT   = 1'b0
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PSUM_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;

  assign full    = {1'b0, a_i} + {{(ACC_W + 1 - PSUM_W){1'b0}}, b_i};
  assign carry_o = full[ACC_W];
  assign sum_o   = (SAT && carry_o) ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/bitblade_acc.sv
// Accumulates len Bitblade partial sums into one ACC_W-bit result.
// Define BITBLADE_ACC_SAT_EN for saturating accumulation with a sticky ovf flag.
module bitblade_acc
  import bitblade_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              ovf,
  output logic              busy
);

`ifdef BITBLADE_ACC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             beat;

  bitblade_sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SatEn)
  ) u_add (
    .a_i     (acc_q),
    .b_i     (in_c),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  assign beat = (state_q == StAcc) && in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          state_d = (len == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (beat) begin
          acc_d = add_sum;
          // Once clamped, further non-negative adds keep clamping, so ovf stays set.
          ovf_d = ovf_q | (SatEn & add_carry);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = acc_q;
  assign ovf       = SatEn ? ovf_q : 1'b0;

endmodule

// File: tb/tb_bitblade_acc.sv
// Randomized and directed bench for bitblade_acc at ACC_W=18 against a sum-of-beats model.
module tb_bitblade_acc;

  localparam int unsigned ACC_W = 18;
  localparam int unsigned LEN_W = 8;
  localparam longint      MAXV  = (64'd1 << ACC_W) - 1;

`ifdef BITBLADE_ACC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [17:0] beat_q[$];

  bitblade_acc #(
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE; beats come from beat_q first, then $urandom.
  task automatic run_job(input int l, input bit gaps, input int hold);
    int          k;
    int          n;
    longint      total;
    logic [17:0] c;
    bit          v;
    longint      exp_sum;
    bit          exp_ovf;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
    total = 0;
    k     = l;
    n     = 0;
    while (k > 0 && n < 1000) begin
      chk("acc_in_ready", 64'(in_ready), 64'd1);
      chk("acc_out_valid", 64'(out_valid), 64'd0);
      v = gaps ? (n % 2 == 0) : 1'b1;
      c = (beat_q.size() > 0) ? beat_q.pop_front() : 18'($urandom);
      in_valid = v;
      in_c     = c;
      start    = $urandom_range(0, 1) == 1;
      len      = LEN_W'($urandom);
      tick();
      if (v) begin
        total += longint'(c);
        k--;
      end
      n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (k > 0) chk("beat_budget", 64'(k), 64'd0);
    if (SatEn) begin
      exp_ovf = total > MAXV;
      exp_sum = exp_ovf ? MAXV : total;
    end else begin
      exp_ovf = 1'b0;
      exp_sum = total % (MAXV + 1);
    end
    chk("done_out_valid", 64'(out_valid), 64'd1);
    chk("done_out_sum", 64'(out_sum), 64'(exp_sum));
    chk("done_ovf", 64'(ovf), 64'(exp_ovf));
    chk("done_in_ready", 64'(in_ready), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_c      = 18'($urandom);
      start     = 1'b1;
      len       = LEN_W'($urandom);
      tick();
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_sum", 64'(out_sum), 64'(exp_sum));
      chk("hold_ovf", 64'(ovf), 64'(exp_ovf));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_out_valid", 64'(out_valid), 64'd0);
    chk("ret_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_c      = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Four sequential beats 1..4.
    beat_q = '{18'd1, 18'd2, 18'd3, 18'd4};
    run_job(4, 1'b0, 0);

    // Zero-length job goes straight to DONE, back-to-back with the previous job.
    run_job(0, 1'b0, 1);

    // Gapped input with a stalled consumer.
    run_job(3, 1'b1, 5);

    // Overflow boundary.
    beat_q = '{18'h3FFFF, 18'h3FFFF};
    run_job(2, 1'b0, 1);

    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(1, 6), $urandom_range(0, 1) == 1, $urandom_range(0, 3));
    end

    // Mid-job reset after 2 of 5 beats.
    start = 1'b1;
    len   = LEN_W'(5);
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_c     = 18'($urandom_range(1, 1000));
      tick();
    end
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_sum", 64'(out_sum), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("post_rst_no_result", 64'(out_valid), 64'd0);
    end
    beat_q = '{18'd7};
    run_job(1, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
